// File: rtl/hub75_pkg.sv
`default_nettype none
// ============================================================================
// Package  : hub75_pkg
// Brief    : Shared state encoding, width helpers and BCM brightness scaling
// Revision : 1.0 - initial release
// ============================================================================
package hub75_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SHIFT     = 3'd1,
        ST_LATCH     = 3'd2,
        ST_DISPLAY   = 3'd3,
        ST_FRAME_END = 3'd4,
        ST_SWAP      = 3'd5
    } state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int col_w(input int cols);
        return idx_w(cols);
    endfunction

    function automatic int row_w(input int rows);
        return idx_w(rows);
    endfunction

    function automatic int plane_w(input int bits);
        return idx_w(bits);
    endfunction

    // Wide enough to hold the longest window value itself, not just its last index.
    function automatic int delay_w(input int base, input int bits);
        return idx_w((base << (bits - 1)) + 1);
    endfunction

    function automatic int unsigned on_time(input int unsigned window, input logic [7:0] level);
        logic [39:0] prod;
        if (level == 8'd0) begin
            return 0;
        end
        prod = 40'(window) * (40'(level) + 40'd1);
        return 32'(prod >> 8);
    endfunction

endpackage
`default_nettype wire

// File: rtl/hub75_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
// Interface : hub75_scan_ctrl_if
// Brief     : Control inputs, frame-buffer read port and panel drive lines
// Revision  : 1.0 - initial release
// ============================================================================
interface hub75_scan_ctrl_if #(
    parameter int COLS      = 64,
    parameter int SCAN_ROWS = 32,
    parameter int BITS      = 8
);
    import hub75_pkg::*;

    localparam int c_cw = col_w(COLS);
    localparam int c_rw = row_w(SCAN_ROWS);
    localparam int c_pw = plane_w(BITS);

    logic            init;
    logic            frame_ready;
    logic [7:0]      brightness;
    logic            rd_en;
    logic [c_cw-1:0] rd_col;
    logic [c_rw-1:0] rd_row;
    logic [c_pw-1:0] rd_bit;
    logic            px_clk;
    logic            latch;
    logic            oe_n;
    logic [c_rw-1:0] row_addr;
    logic            buf_swap;
    logic            frame_done;
    logic            busy;

    modport master (
        input  init, frame_ready, brightness,
        output rd_en, rd_col, rd_row, rd_bit, px_clk, latch, oe_n, row_addr,
        output buf_swap, frame_done, busy
    );

    modport slave (
        output init, frame_ready, brightness,
        input  rd_en, rd_col, rd_row, rd_bit, px_clk, latch, oe_n, row_addr,
        input  buf_swap, frame_done, busy
    );

endinterface
`default_nettype wire

// File: rtl/hub75_bcm_timer.sv
`default_nettype none
// ============================================================================
// Module   : hub75_bcm_timer
// Brief    : BCM display-window counter with brightness-scaled OE on-time
// Revision : 1.0 - initial release
// ============================================================================
module hub75_bcm_timer
    import hub75_pkg::*;
#(
    parameter int BITS       = 8,
    parameter int BASE_DELAY = 16
) (
    input  wire                        clk,
    input  wire                        rst,
    input  wire                        start,
    input  wire [plane_w(BITS)-1:0]    plane,
    input  wire [7:0]                  brightness,
    output logic                       win_done,
    output logic                       oe_on
);

    localparam int c_dw = delay_w(BASE_DELAY, BITS);

    logic [c_dw-1:0] r_cnt;
    logic            r_active;
    logic [c_dw-1:0] w_win;
    logic [c_dw-1:0] w_on;

    always_comb begin
        w_win    = c_dw'(BASE_DELAY << plane);
        w_on     = c_dw'(on_time(32'(w_win), brightness));
        win_done = r_active && (r_cnt == w_win - c_dw'(1));
        // Look-ahead: says whether the panel must be lit in the following cycle.
        if (start) begin
            oe_on = (w_on != '0);
        end else begin
            oe_on = r_active && !win_done && ((r_cnt + c_dw'(1)) < w_on);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_active <= 1'b0;
        end else if (start) begin
            r_cnt    <= '0;
            r_active <= 1'b1;
        end else if (r_active) begin
            if (win_done) begin
                r_active <= 1'b0;
            end else begin
                r_cnt <= r_cnt + c_dw'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/hub75_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hub75_scan_ctrl
// Brief    : HUB75 scan controller: BCM planes, global brightness, buffer swap
// Revision : 1.0 - initial release
// ============================================================================
module hub75_scan_ctrl
    import hub75_pkg::*;
#(
    parameter int COLS         = 64,
    parameter int SCAN_ROWS    = 32,
    parameter int BITS         = 8,
    parameter int BASE_DELAY   = 16,
    parameter int FRAME_REPEAT = 25
) (
    input  wire               clk,
    input  wire               rst,
    hub75_scan_ctrl_if.master bus
);

    localparam int c_cw = col_w(COLS);
    localparam int c_rw = row_w(SCAN_ROWS);
    localparam int c_pw = plane_w(BITS);
    localparam int c_fw = idx_w(FRAME_REPEAT);

    localparam logic [c_cw-1:0] c_col_last = c_cw'(COLS - 1);
    localparam logic [c_rw-1:0] c_row_last = c_rw'(SCAN_ROWS - 1);
    localparam logic [c_pw-1:0] c_pln_last = c_pw'(BITS - 1);
    localparam logic [c_fw-1:0] c_ref_last = c_fw'(FRAME_REPEAT - 1);

    state_t          r_state, w_state_n;
    logic [c_cw-1:0] r_col, w_col_n;
    logic            r_phase, w_phase_n;
    logic [c_rw-1:0] r_row, w_row_n;
    logic [c_pw-1:0] r_plane, w_plane_n;
    logic [c_fw-1:0] r_refresh, w_refresh_n;

    logic            r_rd_en, r_px_clk, r_latch, r_oe_n;
    logic            r_buf_swap, r_frame_done, r_busy;
    logic [c_rw-1:0] r_row_addr;

    logic            w_start, w_win_done, w_oe_on;

    assign w_start = (r_state == ST_LATCH);

    hub75_bcm_timer #(
        .BITS       (BITS),
        .BASE_DELAY (BASE_DELAY)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .start      (w_start),
        .plane      (r_plane),
        .brightness (bus.brightness),
        .win_done   (w_win_done),
        .oe_on      (w_oe_on)
    );

    always_comb begin
        w_state_n   = r_state;
        w_col_n     = r_col;
        w_phase_n   = r_phase;
        w_row_n     = r_row;
        w_plane_n   = r_plane;
        w_refresh_n = r_refresh;
        case (r_state)
            ST_IDLE: begin
                if (bus.init) begin
                    w_state_n = ST_SHIFT;
                    w_col_n   = '0;
                    w_phase_n = 1'b0;
                    w_row_n   = '0;
                    w_plane_n = '0;
                end
            end
            ST_SHIFT: begin
                w_phase_n = !r_phase;
                if (r_phase) begin
                    if (r_col == c_col_last) begin
                        w_col_n   = '0;
                        w_state_n = ST_LATCH;
                    end else begin
                        w_col_n = r_col + c_cw'(1);
                    end
                end
            end
            ST_LATCH: w_state_n = ST_DISPLAY;
            ST_DISPLAY: begin
                if (w_win_done) begin
                    w_state_n = ST_SHIFT;
                    if (r_plane != c_pln_last) begin
                        w_plane_n = r_plane + c_pw'(1);
                    end else if (r_row != c_row_last) begin
                        w_plane_n = '0;
                        w_row_n   = r_row + c_rw'(1);
                    end else begin
                        w_plane_n = '0;
                        w_row_n   = '0;
                        w_state_n = ST_FRAME_END;
                    end
                end
            end
            ST_FRAME_END: begin
                if (r_refresh != c_ref_last) begin
                    w_refresh_n = r_refresh + c_fw'(1);
                end
                if ((r_refresh == c_ref_last) && bus.frame_ready) begin
                    w_state_n = ST_SWAP;
                end else if (bus.init) begin
                    w_state_n = ST_SHIFT;
                end else begin
                    w_state_n = ST_IDLE;
                end
            end
            ST_SWAP: begin
                w_refresh_n = '0;
                w_state_n   = bus.init ? ST_SHIFT : ST_IDLE;
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_col        <= '0;
            r_phase      <= 1'b0;
            r_row        <= '0;
            r_plane      <= '0;
            r_refresh    <= '0;
            r_rd_en      <= 1'b0;
            r_px_clk     <= 1'b0;
            r_latch      <= 1'b0;
            r_oe_n       <= 1'b1;
            r_row_addr   <= '0;
            r_buf_swap   <= 1'b0;
            r_frame_done <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_n;
            r_col        <= w_col_n;
            r_phase      <= w_phase_n;
            r_row        <= w_row_n;
            r_plane      <= w_plane_n;
            r_refresh    <= w_refresh_n;
            r_rd_en      <= (w_state_n == ST_SHIFT) && !w_phase_n;
            r_px_clk     <= (w_state_n == ST_SHIFT) && w_phase_n;
            r_latch      <= (w_state_n == ST_LATCH);
            r_oe_n       <= !((w_state_n == ST_DISPLAY) && w_oe_on);
            r_buf_swap   <= (w_state_n == ST_SWAP);
            r_frame_done <= (w_state_n == ST_FRAME_END);
            r_busy       <= (w_state_n != ST_IDLE);
            // Row lines move only while blanked in the latch cycle to avoid ghosting.
            if (w_state_n == ST_LATCH) begin
                r_row_addr <= w_row_n;
            end
        end
    end

    assign bus.rd_en      = r_rd_en;
    assign bus.rd_col     = r_col;
    assign bus.rd_row     = r_row;
    assign bus.rd_bit     = r_plane;
    assign bus.px_clk     = r_px_clk;
    assign bus.latch      = r_latch;
    assign bus.oe_n       = r_oe_n;
    assign bus.row_addr   = r_row_addr;
    assign bus.buf_swap   = r_buf_swap;
    assign bus.frame_done = r_frame_done;
    assign bus.busy       = r_busy;

endmodule
`default_nettype wire
